// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the hazard scoreboard: jump decode and latency type.
package hazard_pkg;
  localparam int LAT_W_DEF = 3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  typedef logic [LAT_W_DEF-1:0] lat_t;

  function automatic logic is_jump(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_J) || (op == OP_JAL) ||
           ((op == OP_RTYPE) && ((fn == FN_JR) || (fn == FN_JALR)));
  endfunction
endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's forwarding countdown: hold, decrement, or load max(lat, decremented).
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             load,
  input  logic [LAT_W-1:0] lat,
  output logic [LAT_W-1:0] cnt
);
  logic [LAT_W-1:0] cnt_q, cnt_d, dec;

  always_comb begin
    dec   = (cnt_q != '0) ? cnt_q - LAT_W'(1) : cnt_q;
    cnt_d = cnt_q;
    if (!hold) begin
      cnt_d = dec;
      // WAW: a younger write never shortens an older, longer wait
      if (load && (lat > dec)) cnt_d = lat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write scoreboard driving PC / IF/ID / ID/EX control.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int LAT_W    = LAT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [5:0]          id_opcode,
  input  logic [5:0]          id_funct,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_rd_wr,
  input  logic [LAT_W-1:0]    id_lat,
  input  logic                id_serialize,
  input  logic                ex_branch_taken,
  input  logic                mem_busy,
  output logic                pc_wr_en,
  output logic                if_id_wr_en,
  output logic                id_ex_wr_en,
  output logic                if_id_flush,
  output logic                id_ex_bubble,
  output logic [NUM_REGS-1:0] busy_vec
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt
`endif
);
  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic src_haz, ser_haz, stall, jump, issue;

  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    hazard_sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk   (clk),
      .rst_n (rst_n),
      .hold  (mem_busy),
      .load  (issue && id_rd_wr && (id_rd == REG_AW'(r))),
      .lat   (id_lat),
      .cnt   (cnt[r])
    );
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) busy_vec[r] = (cnt[r] != '0);
  end

  assign src_haz = (id_rs_used && (cnt[id_rs] != '0)) || (id_rt_used && (cnt[id_rt] != '0));
  assign ser_haz = id_serialize && (busy_vec != '0);
  assign stall   = id_valid && (src_haz || ser_haz);
  assign jump    = is_jump(id_opcode, id_funct);
  assign issue   = id_valid && !mem_busy && !ex_branch_taken && !stall;

  always_comb begin
    pc_wr_en     = 1'b0;
    if_id_wr_en  = 1'b0;
    id_ex_wr_en  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (!rst_n || mem_busy) begin
      // frozen: everything low, taken branch waits in EX
    end else if (ex_branch_taken) begin
      pc_wr_en     = 1'b1;
      if_id_wr_en  = 1'b1;
      id_ex_wr_en  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (stall) begin
      id_ex_wr_en  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      pc_wr_en     = 1'b1;
      if_id_wr_en  = 1'b1;
      id_ex_wr_en  = 1'b1;
      if_id_flush  = jump;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + 32'((stall && !mem_busy && !ex_branch_taken) ? 1 : 0);
    perf_flush_d = perf_flush_q + 32'(if_id_flush ? 1 : 0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  // default build carries no performance counters
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard with an expected-result queue.
module tb_hazard_scoreboard;
  localparam logic [4:0] NORM = 5'b11100;  // {pc, ifid, idex, flush, bubble}
  localparam logic [4:0] JMP  = 5'b11110;
  localparam logic [4:0] STL  = 5'b00101;
  localparam logic [4:0] BR   = 5'b11111;
  localparam logic [4:0] MB   = 5'b00000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, id_rs_used, id_rt_used, id_rd_wr, id_serialize, ex_branch_taken, mem_busy;
  logic [5:0] id_opcode, id_funct;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [2:0] id_lat;
  logic pc_wr_en, if_id_wr_en, id_ex_wr_en, if_id_flush, id_ex_bubble;
  logic [31:0] busy_vec;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_rd_wr(id_rd_wr), .id_lat(id_lat), .id_serialize(id_serialize),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .pc_wr_en(pc_wr_en),
    .if_id_wr_en(if_id_wr_en), .id_ex_wr_en(id_ex_wr_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .busy_vec(busy_vec)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  typedef struct {
    string      name;
    logic       vld;
    logic [5:0] op, fn;
    logic [4:0] rs; logic rsu;
    logic [4:0] rt; logic rtu;
    logic [4:0] rd; logic rdw;
    logic [2:0] lat;
    logic       ser, br, mb;
    logic [4:0] ctl;
    logic [31:0] busy;
  } vec_t;

  typedef struct {
    string       name;
    logic [4:0]  ctl;
    logic [31:0] busy;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;

  function automatic logic [31:0] b(input int n);
    return 32'd1 << n;
  endfunction

  function automatic vec_t mk(input string nm, input logic vld, input logic [5:0] op, fn,
                              input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                              input logic rtu, input logic [4:0] rd, input logic rdw,
                              input logic [2:0] lat, input logic ser, br, mb,
                              input logic [4:0] ctl, input logic [31:0] busy);
    vec_t v;
    v.name = nm; v.vld = vld; v.op = op; v.fn = fn; v.rs = rs; v.rsu = rsu; v.rt = rt;
    v.rtu = rtu; v.rd = rd; v.rdw = rdw; v.lat = lat; v.ser = ser; v.br = br; v.mb = mb;
    v.ctl = ctl; v.busy = busy;
    return v;
  endfunction

  // producer (load) and a few shorthand rows
  function automatic vec_t prod(input string nm, input logic [4:0] rd, input logic [2:0] lat,
                                input logic [4:0] ctl, input logic [31:0] busy);
    return mk(nm, 1, 6'h23, 6'h00, 0, 0, 0, 0, rd, 1, lat, 0, 0, 0, ctl, busy);
  endfunction

  function automatic vec_t idle(input string nm, input logic br,
                                input logic [4:0] ctl, input logic [31:0] busy);
    return mk(nm, 0, 6'h00, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, br, 0, ctl, busy);
  endfunction

  task automatic apply(input vec_t v);
    id_valid = v.vld; id_opcode = v.op; id_funct = v.fn; id_rs = v.rs; id_rs_used = v.rsu;
    id_rt = v.rt; id_rt_used = v.rtu; id_rd = v.rd; id_rd_wr = v.rdw; id_lat = v.lat;
    id_serialize = v.ser; ex_branch_taken = v.br; mem_busy = v.mb;
  endtask

  task automatic expect_now(input string nm, input logic [4:0] ctl, input logic [31:0] busy);
    exp_t e;
    e.name = nm; e.ctl = ctl; e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [4:0] act;
    act = {pc_wr_en, if_id_wr_en, id_ex_wr_en, if_id_flush, id_ex_bubble};
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL no_expected: output sampled with empty queue");
      return;
    end
    e = exp_q.pop_front();
    if (act !== e.ctl) begin
      n_fail++;
      $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
    end
    n_chk++;
    if (busy_vec !== e.busy) begin
      n_fail++;
      $display("FAIL %s busy_vec: got %h want %h", e.name, busy_vec, e.busy);
    end
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    apply(v);
    expect_now(v.name, v.ctl, v.busy);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t cons;
    // load-use
    vecs.push_back(prod("lu_prod", 8, 1, NORM, 0));
    vecs.push_back(mk("lu_stall", 1, 6'h00, 6'h20, 8, 1, 0, 0, 10, 1, 0, 0, 0, 0, STL, b(8)));
    vecs.push_back(mk("lu_issue", 1, 6'h00, 6'h20, 8, 1, 0, 0, 10, 1, 0, 0, 0, 0, NORM, 0));
    // multi-cycle producer, consumer on rt
    vecs.push_back(prod("mc_prod", 9, 4, NORM, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk("mc_stall", 1, 6'h00, 6'h20, 0, 0, 9, 1, 11, 1, 0, 0, 0, 0, STL, b(9)));
    vecs.push_back(mk("mc_issue", 1, 6'h00, 6'h20, 0, 0, 9, 1, 11, 1, 0, 0, 0, 0, NORM, 0));
    // taken branch overrides a pending stall; the ID write must not land
    vecs.push_back(prod("br_prod", 8, 2, NORM, 0));
    vecs.push_back(mk("br_over", 1, 6'h00, 6'h20, 8, 1, 0, 0, 12, 1, 3, 0, 1, 0, BR, b(8)));
    vecs.push_back(idle("br_after", 0, NORM, b(8)));
    // mem_busy freezes counters
    vecs.push_back(prod("mb_prod", 5, 2, NORM, 0));
    vecs.push_back(mk("mb_hold0", 1, 6'h00, 6'h20, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, MB, b(5)));
    vecs.push_back(mk("mb_hold1", 1, 6'h00, 6'h20, 5, 1, 0, 0, 0, 0, 0, 0, 1, 1, MB, b(5)));
    vecs.push_back(mk("mb_hold2", 1, 6'h00, 6'h20, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, MB, b(5)));
    vecs.push_back(idle("mb_rel_br", 1, BR, b(5)));
    vecs.push_back(idle("mb_dec1", 0, NORM, b(5)));
    vecs.push_back(idle("mb_dec0", 0, NORM, 0));
    // WAW keeps the longer wait; r0 never becomes busy
    vecs.push_back(prod("waw1", 3, 3, NORM, 0));
    vecs.push_back(prod("waw2", 3, 1, NORM, b(3)));
    vecs.push_back(prod("r0_issue", 0, 3, NORM, b(3)));
    vecs.push_back(idle("waw_r0", 0, NORM, b(3)));
    vecs.push_back(idle("waw_done", 0, NORM, 0));
    // serialize waits for an empty scoreboard
    vecs.push_back(prod("ser_prod", 7, 2, NORM, 0));
    vecs.push_back(mk("ser_stall", 1, 6'h00, 6'h20, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, STL, b(7)));
    vecs.push_back(mk("ser_stall", 1, 6'h00, 6'h20, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, STL, b(7)));
    vecs.push_back(mk("ser_go", 1, 6'h00, 6'h20, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, NORM, 0));
    // jump decode
    vecs.push_back(mk("jr", 1, 6'h00, 6'h08, 31, 1, 0, 0, 0, 0, 0, 0, 0, 0, JMP, 0));
    vecs.push_back(mk("jal", 1, 6'h03, 6'h00, 0, 0, 0, 0, 31, 1, 1, 0, 0, 0, JMP, 0));
    vecs.push_back(mk("jalr_stall", 1, 6'h00, 6'h09, 31, 1, 0, 0, 0, 0, 0, 0, 0, 0, STL, b(31)));
    vecs.push_back(mk("jalr_go", 1, 6'h00, 6'h09, 31, 1, 0, 0, 0, 0, 0, 0, 0, 0, JMP, 0));
    vecs.push_back(mk("j", 1, 6'h02, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, JMP, 0));
    vecs.push_back(mk("add_nojump", 1, 6'h00, 6'h20, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, NORM, 0));
    // maximum latency
    vecs.push_back(prod("lat7_prod", 1, 7, NORM, 0));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk("lat7_stall", 1, 6'h00, 6'h20, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, STL, b(1)));
    vecs.push_back(mk("lat7_issue", 1, 6'h00, 6'h20, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0));

    // reset: active-looking inputs must not leak through
    apply(mk("rst", 1, 6'h02, 6'h00, 0, 0, 0, 0, 4, 1, 3, 0, 1, 0, MB, 0));
    expect_now("reset", 5'b00000, 0);
    @(negedge clk); check_out();
    @(negedge clk); check_out_after_hold();
    rst_n = 1'b1;
    apply(idle("idle", 0, NORM, 0));

    foreach (vecs[i]) step(vecs[i]);

    // reset asserted mid-stall clears immediately; first cycle after release is clean
    step(prod("rs_prod", 9, 5, NORM, 0));
    cons = mk("rs_stall", 1, 6'h00, 6'h20, 9, 1, 0, 0, 11, 1, 0, 0, 0, 0, STL, b(9));
    step(cons);
    #2 rst_n = 1'b0;
    #1 expect_now("rst_mid", 5'b00000, 0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    #1 expect_now("rst_release", NORM, 0);
    check_out();
    cons.name = "rst_after"; cons.ctl = NORM; cons.busy = 0;
    step(cons);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // outputs must still be zero after a clock edge with reset held
  task automatic check_out_after_hold();
    expect_now("reset_held", 5'b00000, 0);
    check_out();
  endtask
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the pipeline hazard unit. It keeps a per-register scoreboard of in-flight destination writes, each with a countdown of cycles until its result is forwardable. This lets the pipeline stall correctly for variable-latency producers (loads, multi-cycle ALU ops, slow memory), not only single-cycle load-use. It sits beside the ID stage and drives the PC, IF/ID and ID/EX enables, bubbles and flushes.

Parameters:
NUM_REGS, 32, architectural registers tracked; register 0 is never busy
REG_AW, 5, register index width, equal to clog2(NUM_REGS)
LAT_W, 3, latency field width; maximum latency is 2^LAT_W-1

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_opcode  in  6  ID opcode
id_funct  in  6  ID funct
id_rs  in  REG_AW  source register rs
id_rt  in  REG_AW  source register rt
id_rs_used  in  1  rs is read
id_rt_used  in  1  rt is read
id_rd  in  REG_AW  destination register
id_rd_wr  in  1  instruction writes id_rd
id_lat  in  LAT_W  bubbles a consumer needs after this producer (ALU 0, load 1)
id_serialize  in  1  instruction must wait for an empty scoreboard
ex_branch_taken  in  1  branch resolved taken in EX
mem_busy  in  1  memory stall; freezes the whole pipeline
pc_wr_en  out  1  PC update enable
if_id_wr_en  out  1  IF/ID register enable
id_ex_wr_en  out  1  ID/EX register enable
if_id_flush  out  1  clear IF/ID
id_ex_bubble  out  1  load a NOP into ID/EX
busy_vec  out  NUM_REGS  bit r set when cnt[r] != 0

Behaviour:
- State: cnt[r], LAT_W bits per register. The scoreboard flop for r=0 is tied to 0.
- Reset (asynchronous, rst_n low): all cnt are 0. While rst_n is low: pc_wr_en=0, if_id_wr_en=0, id_ex_wr_en=0, if_id_flush=0, id_ex_bubble=0, busy_vec=0.
- Source hazard: src_haz = (id_rs_used & cnt[id_rs]!=0) | (id_rt_used & cnt[id_rt]!=0).
- Serialize hazard: ser_haz = id_serialize & (busy_vec!=0).
- Stall: stall = id_valid & (src_haz | ser_haz).
- Jump: jump = id_opcode is 0x02 or 0x03, or (id_opcode 0x00 and id_funct 0x08 or 0x09).
- Priority, evaluated combinationally each cycle:
  1. mem_busy: pc_wr_en, if_id_wr_en and id_ex_wr_en are 0; flush and bubble are 0; cnt holds. Any taken branch is held in EX and acted on the first cycle mem_busy is low.
  2. ex_branch_taken: pc_wr_en=1, if_id_wr_en=1, id_ex_wr_en=1, if_id_flush=1, id_ex_bubble=1. The stall is overridden.
  3. stall: pc_wr_en=0, if_id_wr_en=0, id_ex_wr_en=1, id_ex_bubble=1, if_id_flush=0.
  4. Otherwise: all enables 1, id_ex_bubble=0, if_id_flush=jump.
- Issue occurs when id_valid & ~mem_busy & ~ex_branch_taken & ~stall.
- Counter update, only when ~mem_busy: every nonzero cnt decrements by 1.
- On an issue with id_rd_wr and id_rd!=0: cnt[id_rd] <= max(id_lat, cnt[id_rd]-1), which covers WAW. The issue write overrides the decrement for that register.
- Latency rule: a consumer in ID the cycle after a producer issues with lat L sees L bubbles. L=0 means no stall.
- busy_vec is a direct function of cnt (registered state).
- rst_n asserted mid-stall clears the scoreboard immediately. The first cycle after release is hazard-free.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0]. These count cycles with stall&~mem_busy&~ex_branch_taken, and cycles with if_id_flush=1. Both wrap at 2^32 and reset to 0.
- Undefined: these ports and their counters do not exist.

Decomposition:
- Package hazard_pkg: OP_J=6'h02, OP_JAL=6'h03, OP_RTYPE=6'h00, FN_JR=6'h08, FN_JALR=6'h09, default LAT_W, and the lat_t typedef.
- One sub-module, hazard_sb_entry: a single register's countdown with load/max/decrement/hold. It is generated NUM_REGS-1 times.

Test Plan:
- Load-use: issue rd=8 with lat=1, then next ID reads rs=8 -> exactly 1 cycle with pc_wr_en=0 and id_ex_bubble=1, then issue.
- Multi-cycle: issue rd=9 with lat=4, then a consumer of rt=9 -> 4 stall cycles, busy_vec[9] set for 4 cycles.
- Branch over stall: stall pending on rs=8 while ex_branch_taken=1 -> pc_wr_en=1, if_id_flush=1, id_ex_bubble=1, cnt unchanged by the ID instruction.
- mem_busy: set for 3 cycles with cnt[5]=2 -> all enables 0 and cnt[5] stays 2; after release it decrements to 1, then 0.
- WAW and r0: issue rd=3 lat=3, then rd=3 lat=1 -> cnt[3]=2. Issue rd=0 lat=3 -> busy_vec[0] stays 0.
- Serialize/jump: id_serialize with busy_vec!=0 stalls until busy_vec=0. A JR (opcode 0x00, funct 0x08) unstalled gives if_id_flush=1. Reset asserted mid-stall gives busy_vec=0 immediately.
